chunked_addsub_ctrl: RTL and testbench
======================================

Name: chunked_addsub_ctrl

Overview:
Parametrised multi-cycle add/subtract accumulator controller for the switch-driven adder lab datapath.
- Holds accumulator register B, loaded from switches on a LoadB press.
- On each Run press, adds or subtracts the switch operand into B, CHUNK bits per clock, with carry chained between slices.
- Generalises the single-cycle 16-bit adder control: parametrised width, edge-detected buttons, subtract mode, Done/Busy status and signed overflow.

Parameters:
- WIDTH, 16, accumulator and operand width in bits.
- CHUNK, 4, bits added per COMPUTE cycle. Must divide WIDTH. NCH = WIDTH/CHUNK.

Ports:
- Clk  input  1  clock.
- Reset  input  1  synchronous, active-high; clock Clk.
- LoadB  input  1  load button, level; rising edge acts.
- Run  input  1  run button, level; rising edge acts.
- Sub  input  1  mode, sampled at the Run edge: 0 = add, 1 = subtract.
- SW  input  WIDTH  switch operand.
- B  output  WIDTH  accumulator value.
- C_out  output  1  carry out of the last operation (subtract: 1 = no borrow).
- Ovf  output  1  signed overflow of the last operation.
- Busy  output  1  high while in COMPUTE.
- Done  output  1  one-cycle pulse when the result is final.

Behaviour:
- Reset (synchronous, highest priority):
  - B = 0, C_out = 0, Ovf = 0, Busy = 0, Done = 0, state = IDLE.
  - Edge-detect history registers reset to 1, so a button held through Reset produces no edge.
- Edge detect: an edge is registered when the button input is 1 and its previous sampled value was 0. One edge = one action.
- States are IDLE, COMPUTE, DONE.
- IDLE:
  - LoadB edge: B <= SW at that clock edge. C_out and Ovf unchanged. Stay in IDLE.
  - Run edge, no LoadB edge: latch A = SW (or ~SW if Sub), carry = Sub, idx = 0, latch the mode; go to COMPUTE.
  - LoadB and Run edges in the same cycle: load only; the Run edge is discarded.
- COMPUTE, idx = 0..NCH-1, one cycle each:
  - {carry, B[idx*CHUNK +: CHUNK]} <= B slice + A slice + carry.
  - On the last slice, record the carry-in to the MSB for Ovf.
  - After NCH cycles, go to DONE.
  - Busy = 1 throughout.
  - LoadB and Run edges in COMPUTE or DONE are ignored, not queued.
- DONE, exactly one cycle:
  - Done = 1.
  - C_out = final carry.
  - Ovf = carry-into-MSB XOR carry-out.
  - Go to IDLE.
- Latency: Run edge sampled in cycle t gives COMPUTE in cycles t+1..t+NCH and Done in cycle t+NCH+1. B is final in that cycle.
- Visibility: partial B is visible during COMPUTE (low slices updated first). C_out and Ovf hold until the next DONE or Reset.
- Arithmetic: modulo 2^WIDTH, wraps with no error beyond Ovf. Subtract computes B + ~A + 1.
- Reset mid-COMPUTE: abort, apply reset values, no Done pulse.

Optional Feature:
Macro CHUNKED_ADDSUB_SAT_EN.
- Defined: in DONE, if Ovf = 1, B is clamped at that same clock edge.
  - Clamp to 2^(WIDTH-1)-1 when the operands were non-negative (positive overflow).
  - Clamp to 2^(WIDTH-1) when the operands were negative.
  - Ovf still reports 1.
- Undefined: B wraps; no clamping logic is synthesised.

Test Plan (WIDTH=16, CHUNK=4):
1. Reset; LoadB edge with SW=0x1234; then Run edge with SW=0x0FFF, Sub=0 -> Busy high 4 cycles; Done in 5th cycle after edge cycle; B=0x2233, C_out=0, Ovf=0.
2. B=0xFFFF; Run edge with SW=0x0001, Sub=0 -> B=0x0000, C_out=1, Ovf=0.
3. B=0x7FFF; Run edge with SW=0x0001, Sub=0 -> B=0x8000, Ovf=1. With CHUNKED_ADDSUB_SAT_EN: B=0x7FFF, Ovf=1.
4. B=0x0005; Run edge with SW=0x0007, Sub=1 -> B=0xFFFE, C_out=0, Ovf=0.
5. Reset during 2nd COMPUTE cycle -> next cycle B=0, Busy=0, no Done. Run held high across Reset release -> no compute starts.
6. LoadB and Run edges in the same IDLE cycle with SW=0x00AA -> B=0x00AA, no COMPUTE. Run edge during COMPUTE -> ignored; exactly one Done pulse.

Source files
------------

// File: rtl/chunked_addsub_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : chunked_addsub_ctrl
// Brief   : Multi-cycle add/subtract accumulator, CHUNK bits per clock.
//           Optional saturation on signed overflow: CHUNKED_ADDSUB_SAT_EN.
// Revision: 1.0 - initial release
// ============================================================================
module chunked_addsub_ctrl #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             LoadB,
  input  logic             Run,
  input  logic             Sub,
  input  logic [WIDTH-1:0] SW,
  output logic [WIDTH-1:0] B,
  output logic             C_out,
  output logic             Ovf,
  output logic             Busy,
  output logic             Done
);

  localparam int NCH  = WIDTH / CHUNK;
  localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;

  logic [WIDTH-1:0]  r_b;
  logic [WIDTH-1:0]  r_a;
  logic              r_carry;
  logic              r_cout;
  logic              r_ovf;
  logic [IDXW-1:0]   r_idx;
  logic              r_loadb_d;
  logic              r_run_d;

  logic              w_load_edge;
  logic              w_run_edge;
  logic              w_run_go;
  logic              w_last;
  logic [31:0]       w_base;
  logic [CHUNK-1:0]  w_bsl;
  logic [CHUNK-1:0]  w_asl;
  logic [CHUNK:0]    w_sum;
  logic              w_cin_msb;
  logic              w_ovf;

  assign w_load_edge = LoadB & ~r_loadb_d;
  assign w_run_edge  = Run & ~r_run_d;
  assign w_run_go    = w_run_edge & ~w_load_edge;
  assign w_last      = (r_idx == IDXW'(NCH - 1));

  assign w_base = 32'(r_idx) * 32'(CHUNK);
  assign w_bsl  = r_b[w_base +: CHUNK];
  assign w_asl  = r_a[w_base +: CHUNK];
  assign w_sum  = {1'b0, w_bsl} + {1'b0, w_asl} + {{CHUNK{1'b0}}, r_carry};

  // Carry into the top bit recovered from the sum bit and its two operand bits.
  assign w_cin_msb = w_sum[CHUNK-1] ^ w_bsl[CHUNK-1] ^ w_asl[CHUNK-1];
  assign w_ovf     = w_cin_msb ^ w_sum[CHUNK];

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_run_go) w_next = S_COMPUTE;
      S_COMPUTE: if (w_last)   w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_b       <= '0;
      r_a       <= '0;
      r_carry   <= 1'b0;
      r_cout    <= 1'b0;
      r_ovf     <= 1'b0;
      r_idx     <= '0;
      r_loadb_d <= 1'b1;
      r_run_d   <= 1'b1;
    end else begin
      r_loadb_d <= LoadB;
      r_run_d   <= Run;
      case (r_state)
        S_IDLE: begin
          if (w_load_edge) begin
            r_b <= SW;
          end else if (w_run_edge) begin
            r_a     <= Sub ? ~SW : SW;
            r_carry <= Sub;
            r_idx   <= '0;
          end
        end
        S_COMPUTE: begin
          r_b[w_base +: CHUNK] <= w_sum[CHUNK-1:0];
          r_carry              <= w_sum[CHUNK];
          r_idx                <= r_idx + IDXW'(1);
          // Status is committed with the last slice so it is valid during DONE.
          if (w_last) begin
            r_cout <= w_sum[CHUNK];
            r_ovf  <= w_ovf;
`ifdef CHUNKED_ADDSUB_SAT_EN
            if (w_ovf) begin
              r_b <= w_sum[CHUNK-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                    : {1'b1, {(WIDTH-1){1'b0}}};
            end
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign B     = r_b;
  assign C_out = r_cout;
  assign Ovf   = r_ovf;
  assign Busy  = (r_state == S_COMPUTE);
  assign Done  = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_chunked_addsub_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_chunked_addsub_ctrl
// Brief   : Directed self-checking bench for chunked_addsub_ctrl (16/4).
// Revision: 1.0 - initial release
// ============================================================================
module tb_chunked_addsub_ctrl;

  logic        Clk;
  logic        Reset;
  logic        LoadB;
  logic        Run;
  logic        Sub;
  logic [15:0] SW;
  logic [15:0] B;
  logic        C_out;
  logic        Ovf;
  logic        Busy;
  logic        Done;

  int n_checks = 0;
  int n_pass   = 0;

  chunked_addsub_ctrl #(.WIDTH(16), .CHUNK(4)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .LoadB (LoadB),
    .Run   (Run),
    .Sub   (Sub),
    .SW    (SW),
    .B     (B),
    .C_out (C_out),
    .Ovf   (Ovf),
    .Busy  (Busy),
    .Done  (Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic load_b(input logic [15:0] v);
    LoadB = 1'b1;
    SW    = v;
    tick();
    LoadB = 1'b0;
    tick();
    check("load_B", 32'(B), 32'(v));
  endtask

  // Run edge, then four Busy cycles, Done in the fifth, then Done drops.
  task automatic run_op(input string tag, input logic [15:0] sw, input logic sub,
                        input logic [15:0] eb, input logic ec, input logic eo);
    Run = 1'b1;
    SW  = sw;
    Sub = sub;
    tick();
    Run = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check({tag, "_busy"}, 32'(Busy), 32'd1);
      check({tag, "_nodone"}, 32'(Done), 32'd0);
      tick();
    end
    check({tag, "_done"}, 32'(Done), 32'd1);
    check({tag, "_busy_lo"}, 32'(Busy), 32'd0);
    check({tag, "_B"}, 32'(B), 32'(eb));
    check({tag, "_cout"}, 32'(C_out), 32'(ec));
    check({tag, "_ovf"}, 32'(Ovf), 32'(eo));
    tick();
    check({tag, "_done_pulse"}, 32'(Done), 32'd0);
    check({tag, "_B_hold"}, 32'(B), 32'(eb));
  endtask

  logic [15:0] exp_sat;
  int          done_cnt;

  initial begin
    Reset = 1'b1;
    LoadB = 1'b0;
    Run   = 1'b0;
    Sub   = 1'b0;
    SW    = 16'h0;
    tick();
    tick();
    check("rst_B", 32'(B), 32'h0);
    check("rst_cout", 32'(C_out), 32'd0);
    check("rst_ovf", 32'(Ovf), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    Reset = 1'b0;
    tick();

    // 1: basic add, with partial-B visibility after the first slice
    load_b(16'h1234);
    Run = 1'b1;
    SW  = 16'h0FFF;
    Sub = 1'b0;
    tick();
    Run = 1'b0;
    check("t1_B_before", 32'(B), 32'h1234);
    tick();
    check("t1_B_slice0", 32'(B), 32'h1233);
    tick();
    tick();
    tick();
    check("t1_done", 32'(Done), 32'd1);
    check("t1_B", 32'(B), 32'h2233);
    check("t1_cout", 32'(C_out), 32'd0);
    check("t1_ovf", 32'(Ovf), 32'd0);
    tick();

    // 2: unsigned wrap with carry out
    load_b(16'hFFFF);
    run_op("t2", 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);

    // 3: positive signed overflow
`ifdef CHUNKED_ADDSUB_SAT_EN
    exp_sat = 16'h7FFF;
`else
    exp_sat = 16'h8000;
`endif
    load_b(16'h7FFF);
    run_op("t3", 16'h0001, 1'b0, exp_sat, 1'b0, 1'b1);

    // 4: subtract with borrow; status from t3 must survive the load
    load_b(16'h0005);
    check("t4_ovf_held", 32'(Ovf), 32'd1);
    run_op("t4", 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);

    // 5: reset in 2nd COMPUTE cycle while Run stays high
    load_b(16'h0010);
    Run = 1'b1;
    SW  = 16'h0001;
    Sub = 1'b0;
    tick();
    tick();
    check("t5_busy_c2", 32'(Busy), 32'd1);
    Reset = 1'b1;
    tick();
    check("t5_B_rst", 32'(B), 32'h0);
    check("t5_busy_rst", 32'(Busy), 32'd0);
    check("t5_done_rst", 32'(Done), 32'd0);
    Reset = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (Busy || Done) done_cnt++;
    end
    check("t5_no_start", 32'(done_cnt), 32'd0);
    Run = 1'b0;
    tick();

    // 6a: simultaneous LoadB and Run edges -> load only
    LoadB = 1'b1;
    Run   = 1'b1;
    SW    = 16'h00AA;
    tick();
    LoadB = 1'b0;
    Run   = 1'b0;
    check("t6_B_load", 32'(B), 32'h00AA);
    check("t6_no_busy", 32'(Busy), 32'd0);
    tick();
    check("t6_no_busy2", 32'(Busy), 32'd0);

    // 6b: edges during COMPUTE are ignored, exactly one Done
    Run = 1'b1;
    SW  = 16'h0001;
    tick();
    Run = 1'b0;
    done_cnt = 0;
    for (int i = 0; i < 14; i++) begin
      if (i == 1) begin
        Run   = 1'b1;
        LoadB = 1'b1;
        SW    = 16'h5555;
      end
      if (i == 2) begin
        Run   = 1'b0;
        LoadB = 1'b0;
      end
      if (Done) done_cnt++;
      tick();
    end
    check("t6_one_done", 32'(done_cnt), 32'd1);
    check("t6_B", 32'(B), 32'h00AB);
    check("t6_idle", 32'(Busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
